// File: rtl/neuro_op_sequencer_pkg.sv
// Shared definitions for the op sequencer: state encoding, control-register
// addresses seen by the register file, and default bus widths.
package neuro_op_sequencer_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;

   // Control-register window; host writes here are blocked while critical=1
   localparam logic [15:0] REG_ADDR_BEGIN   = 16'h8000;
   localparam logic [15:0] REG_ADDR_OFFSET  = 16'h8001;
   localparam logic [15:0] REG_ADDR_DEST    = 16'h8002;
   localparam logic [15:0] REG_ADDR_NUMOPS  = 16'h8003;
   localparam logic [15:0] REG_ADDR_REVERSE = 16'h8004;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_READ,
      ST_WAIT,
      ST_WRITE,
      ST_DONE
   } seq_state_t;

endpackage

// File: rtl/neuro_seq_addr_gen.sv
// Combinational source/destination address for op index idx; all arithmetic
// wraps modulo 2^ADDR_W.
module neuro_seq_addr_gen
   import neuro_op_sequencer_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0] i_off_base,
   input  logic [ADDR_W-1:0] i_dest_base,
   input  logic [15:0]       i_idx,
   input  logic [15:0]       i_num_ops,
   input  logic              i_reverse,
   output logic [ADDR_W-1:0] o_src_addr,
   output logic [ADDR_W-1:0] o_dst_addr
);
   logic [ADDR_W-1:0] w_idx;
   logic [ADDR_W-1:0] w_num;
   logic [ADDR_W-1:0] w_rev_addr;
   logic [ADDR_W-1:0] w_fwd_addr;

   assign w_idx      = ADDR_W'(i_idx);
   assign w_num      = ADDR_W'(i_num_ops);
   assign w_fwd_addr = i_dest_base + w_idx;
   assign w_rev_addr = i_dest_base + w_num - ADDR_W'(1) - w_idx;

   assign o_src_addr = i_off_base + w_idx;
   assign o_dst_addr = i_reverse ? w_rev_addr : w_fwd_addr;

endmodule

// File: rtl/neuro_op_sequencer.sv
// Copies numOps cache words from a shadowed source base to a shadowed
// destination base (forward or reversed) over the shared cache port.
module neuro_op_sequencer
   import neuro_op_sequencer_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fsmBeginOp,
   input  logic [ADDR_W-1:0] offsetReg,
   input  logic [ADDR_W-1:0] destReg,
   input  logic [15:0]       numOpsReg,
   input  logic              writeReverse,
   output logic              fsmReadyForNextOp,
   output logic              critical,
   output logic [ADDR_W-1:0] seqAddr,
   output logic              seqWE,
   output logic [DATA_W-1:0] seqDataOut,
   input  logic [DATA_W-1:0] seqDataIn,
   output logic [15:0]       opCount
);
   localparam logic [1:0] WAIT_LOAD = 2'(READ_LAT - 1);

   seq_state_t        r_state;
   seq_state_t        w_state_next;
   logic [ADDR_W-1:0] r_off;
   logic [ADDR_W-1:0] r_dest;
   logic [15:0]       r_num;
   logic              r_rev;
   logic [15:0]       r_idx;
   logic [15:0]       r_op_count;
   logic [1:0]        r_wait_cnt;
   logic [DATA_W-1:0] r_data;
   logic              r_ready;
   logic [ADDR_W-1:0] w_src_addr;
   logic [ADDR_W-1:0] w_dst_addr;
   logic              w_last_op;
   logic              w_wait_done;

   neuro_seq_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .i_off_base  (r_off),
      .i_dest_base (r_dest),
      .i_idx       (r_idx),
      .i_num_ops   (r_num),
      .i_reverse   (r_rev),
      .o_src_addr  (w_src_addr),
      .o_dst_addr  (w_dst_addr)
   );

   assign w_last_op   = (r_idx == r_num - 16'd1);
   assign w_wait_done = (r_wait_cnt == 2'd0);

   always_comb begin
      w_state_next = r_state;
      seqAddr      = '0;
      seqWE        = 1'b0;
      critical     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (fsmBeginOp) w_state_next = ST_START;
         end
         ST_START: begin
            critical     = 1'b1;
            w_state_next = (r_num == 16'd0) ? ST_DONE : ST_READ;
         end
         ST_READ: begin
            critical     = 1'b1;
            seqAddr      = w_src_addr;
            w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            critical = 1'b1;
            seqAddr  = w_src_addr;
            if (w_wait_done) w_state_next = ST_WRITE;
         end
         ST_WRITE: begin
            critical     = 1'b1;
            seqAddr      = w_dst_addr;
            seqWE        = 1'b1;
            w_state_next = w_last_op ? ST_DONE : ST_READ;
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Ready rises one cycle after IDLE is re-entered, and only if no new run
   // is being accepted on that cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ready    <= 1'b1;
         r_off      <= '0;
         r_dest     <= '0;
         r_num      <= '0;
         r_rev      <= 1'b0;
         r_idx      <= '0;
         r_op_count <= '0;
         r_wait_cnt <= '0;
         r_data     <= '0;
      end else begin
         r_state <= w_state_next;
         r_ready <= (r_state == ST_IDLE) && (w_state_next == ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               if (fsmBeginOp) begin
                  r_off      <= offsetReg;
                  r_dest     <= destReg;
                  r_num      <= numOpsReg;
                  r_rev      <= writeReverse;
                  r_idx      <= '0;
                  r_op_count <= '0;
               end
            end
            ST_READ: begin
               r_wait_cnt <= WAIT_LOAD;
            end
            ST_WAIT: begin
               if (w_wait_done) r_data <= seqDataIn;
               else             r_wait_cnt <= r_wait_cnt - 2'd1;
            end
            ST_WRITE: begin
               r_op_count <= r_op_count + 16'd1;
               r_idx      <= r_idx + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign fsmReadyForNextOp = r_ready;
   assign seqDataOut        = r_data;
   assign opCount           = r_op_count;

endmodule
